// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and a debug/loader port.
// One access at a time; each access ends with a one-cycle ack carrying registered read data.
module mem_port_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  input  logic          dbg_lock,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_dbg
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_t        state;
  state_t        next_state;
  logic          last_grant;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata_q;
  logic [1:0]    lat_cnt;
  logic          cpu_ok;
  logic          any_req;
  logic          pick_dbg;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    cpu_ok   = cpu_req & ~dbg_lock;
    any_req  = cpu_ok | dbg_req;
    pick_dbg = dbg_req & (~cpu_ok | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = lat_we ? RESP : WAIT;
      WAIT:    if (lat_cnt == 2'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant_dbg  <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_cnt    <= 2'd0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_we     <= pick_dbg ? dbg_we    : cpu_we;
            lat_addr   <= pick_dbg ? dbg_addr  : cpu_addr;
            lat_wdata  <= pick_dbg ? dbg_wdata : cpu_wdata;
            grant_dbg  <= pick_dbg;
            last_grant <= pick_dbg;
          end
        end
        ACCESS: begin
          if (!lat_we) lat_cnt <= LAT_INIT;
        end
        WAIT: begin
          if (lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
          else                 rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Writes ack with zero data; only the granted side ever sees the ack.
  always_comb begin
    mem_re    = (state == ACCESS) & ~lat_we;
    mem_we    = (state == ACCESS) &  lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    busy      = (state != IDLE);
    cpu_ack   = (state == RESP) & ~grant_dbg;
    dbg_ack   = (state == RESP) &  grant_dbg;
    cpu_rdata = (cpu_ack & ~lat_we) ? rdata_q : '0;
    dbg_rdata = (dbg_ack & ~lat_we) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: table-driven single accesses plus contention, lock, reset and latency sequences.
// Expected acks and memory strobes go into scoreboard queues and are popped as the DUT produces them.
module tb_mem_port_arbiter;

  typedef struct {
    logic       is_dbg;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic       is_dbg;
    logic [7:0] rdata;
    int         cycle;
  } ack_exp_t;

  typedef struct {
    int         cycle;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       is_dbg;
  } acc_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic       cpu_req1, cpu_we1, dbg_req1, dbg_we1, dbg_lock1;
  logic [7:0] cpu_addr1, cpu_wdata1, dbg_addr1, dbg_wdata1;
  logic [7:0] cpu_rdata1, dbg_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic       cpu_ack1, dbg_ack1, mem_re1, mem_we1, busy1, grant_dbg1;

  logic       cpu_req3, cpu_we3, dbg_req3, dbg_we3, dbg_lock3;
  logic [7:0] cpu_addr3, cpu_wdata3, dbg_addr3, dbg_wdata3;
  logic [7:0] cpu_rdata3, dbg_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic       cpu_ack3, dbg_ack3, mem_re3, mem_we3, busy3, grant_dbg3;

  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  ack_exp_t ack_q[$];
  acc_exp_t acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
    .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
    .dbg_req(dbg_req1), .dbg_we(dbg_we1), .dbg_addr(dbg_addr1), .dbg_wdata(dbg_wdata1),
    .dbg_rdata(dbg_rdata1), .dbg_ack(dbg_ack1), .dbg_lock(dbg_lock1),
    .mem_re(mem_re1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1), .grant_dbg(grant_dbg1)
  );

  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
    .dbg_req(dbg_req3), .dbg_we(dbg_we3), .dbg_addr(dbg_addr3), .dbg_wdata(dbg_wdata3),
    .dbg_rdata(dbg_rdata3), .dbg_ack(dbg_ack3), .dbg_lock(dbg_lock3),
    .mem_re(mem_re3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .grant_dbg(grant_dbg3)
  );

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = ~(8'(i));
    if (i == 16) v = 8'hA5;
    return v;
  endfunction

  // Memory models: read data appears only in the cycle MEM_LAT after the strobe, zero otherwise.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_val(i);
        mem3[i] <= init_val(i);
      end
    end else begin
      if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
      if (mem_we3) mem3[mem_addr3] <= mem_wdata3;
    end
    pipe1    <= mem_re1 ? mem1[mem_addr1] : 8'h00;
    pipe3[0] <= mem_re3 ? mem3[mem_addr3] : 8'h00;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign mem_rdata1 = pipe1;
  assign mem_rdata3 = pipe3[2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expectAck(input logic is_dbg, input logic [7:0] rdata, input int cycle);
    ack_exp_t e;
    e.is_dbg = is_dbg;
    e.rdata  = rdata;
    e.cycle  = cycle;
    ack_q.push_back(e);
  endtask

  task automatic expectAccess(input int cycle, input logic we, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic is_dbg);
    acc_exp_t e;
    e.cycle  = cycle;
    e.we     = we;
    e.addr   = addr;
    e.wdata  = wdata;
    e.is_dbg = is_dbg;
    acc_q.push_back(e);
  endtask

  // Scoreboard consumer for the MEM_LAT=1 instance.
  always @(negedge clk) begin
    ack_exp_t a;
    acc_exp_t m;
    if (cpu_ack1 || dbg_ack1) begin
      checkOutput("ack_exclusive", 64'(cpu_ack1 & dbg_ack1), 0);
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got cpu_ack=%0b dbg_ack=%0b expected none (cycle %0d)",
                 cpu_ack1, dbg_ack1, cyc);
      end else begin
        a = ack_q.pop_front();
        checkOutput("ack_owner", 64'(dbg_ack1), 64'(a.is_dbg));
        checkOutput("ack_cycle", 64'(cyc), 64'(a.cycle));
        checkOutput("ack_rdata", 64'(dbg_ack1 ? dbg_rdata1 : cpu_rdata1), 64'(a.rdata));
        checkOutput("other_rdata", 64'(dbg_ack1 ? cpu_rdata1 : dbg_rdata1), 0);
      end
    end
    if (mem_re1 || mem_we1) begin
      checkOutput("strobe_exclusive", 64'(mem_re1 & mem_we1), 0);
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_access: got re=%0b we=%0b addr=%0h expected none (cycle %0d)",
                 mem_re1, mem_we1, mem_addr1, cyc);
      end else begin
        m = acc_q.pop_front();
        checkOutput("acc_cycle", 64'(cyc), 64'(m.cycle));
        checkOutput("acc_we", 64'(mem_we1), 64'(m.we));
        checkOutput("acc_addr", 64'(mem_addr1), 64'(m.addr));
        checkOutput("acc_wdata", 64'(mem_wdata1), 64'(m.wdata));
        checkOutput("acc_grant", 64'(grant_dbg1), 64'(m.is_dbg));
      end
    end
  end

  // Issue one access from an idle DUT, wait for its ack, then release the request.
  task automatic applyStimulus(input vec_t v);
    bit got = 0;
    expectAccess(cyc + 1, v.we, v.addr, v.wdata, v.is_dbg);
    expectAck(v.is_dbg, v.exp_rdata, cyc + (v.we ? 2 : 3));
    if (v.is_dbg) begin
      dbg_req1 = 1'b1; dbg_we1 = v.we; dbg_addr1 = v.addr; dbg_wdata1 = v.wdata;
    end else begin
      cpu_req1 = 1'b1; cpu_we1 = v.we; cpu_addr1 = v.addr; cpu_wdata1 = v.wdata;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (v.is_dbg ? dbg_ack1 : cpu_ack1) begin
        got = 1;
        break;
      end
    end
    checkOutput("ack_timeout", 64'(got), 1);
    @(posedge clk);
    #1;
    cpu_req1 = 1'b0;
    dbg_req1 = 1'b0;
  endtask

  task automatic waitDrain(input int max);
    int n = 0;
    while ((ack_q.size() != 0 || acc_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_ack", 64'(ack_q.size()), 0);
    checkOutput("drain_acc", 64'(acc_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [10];
    int   k, cpu_n, dbg_n, cpu_at_unlock, re_cyc, ack_cyc;
    logic [7:0] rd;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h11, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'h20, 8'h22, 8'h3C};
    vecs[3] = '{1'b0, 1'b1, 8'h33, 8'h77, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h33, 8'h44, 8'h77};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h55, 8'hA5};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'h81, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 8'hFF, 8'h66, 8'h81};
    vecs[8] = '{1'b0, 1'b0, 8'h00, 8'h99, 8'hFF};
    vecs[9] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F};

    rst = 1'b1; mem_load = 1'b1;
    cpu_req1 = 0; cpu_we1 = 0; cpu_addr1 = 0; cpu_wdata1 = 0;
    dbg_req1 = 0; dbg_we1 = 0; dbg_addr1 = 0; dbg_wdata1 = 0; dbg_lock1 = 0;
    cpu_req3 = 0; cpu_we3 = 0; cpu_addr3 = 0; cpu_wdata3 = 0;
    dbg_req3 = 0; dbg_we3 = 0; dbg_addr3 = 0; dbg_wdata3 = 0; dbg_lock3 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; mem_load = 1'b0;

    @(negedge clk);
    checkOutput("reset_outputs",
                {busy1, cpu_ack1, dbg_ack1, cpu_rdata1, dbg_rdata1, mem_re1, mem_we1,
                 mem_addr1, mem_wdata1, grant_dbg1}, 0);
    @(posedge clk);
    #1;

    $display("[TB] single-access vectors");
    foreach (vecs[i]) begin
      checkOutput("idle_busy", 64'(busy1), 0);
      applyStimulus(vecs[i]);
    end
    waitDrain(10);

    $display("[TB] contention after reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = cyc;
    expectAccess(k + 1,  1'b0, 8'h10, 8'h00, 1'b0); expectAck(1'b0, 8'hA5, k + 3);
    expectAccess(k + 5,  1'b0, 8'h20, 8'h00, 1'b1); expectAck(1'b1, 8'h3C, k + 7);
    expectAccess(k + 9,  1'b0, 8'h10, 8'h00, 1'b0); expectAck(1'b0, 8'hA5, k + 11);
    expectAccess(k + 13, 1'b0, 8'h20, 8'h00, 1'b1); expectAck(1'b1, 8'h3C, k + 15);
    cpu_req1 = 1; cpu_we1 = 0; cpu_addr1 = 8'h10; cpu_wdata1 = 8'h00;
    dbg_req1 = 1; dbg_we1 = 0; dbg_addr1 = 8'h20; dbg_wdata1 = 8'h00;
    cpu_n = 0; dbg_n = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cpu_ack1) cpu_n++;
      if (dbg_ack1) dbg_n++;
      @(posedge clk);
      #1;
      if (cpu_n == 2) cpu_req1 = 0;
      if (dbg_n == 2) begin
        dbg_req1 = 0;
        break;
      end
    end
    checkOutput("contend_cpu_acks", 64'(cpu_n), 2);
    checkOutput("contend_dbg_acks", 64'(dbg_n), 2);
    cpu_req1 = 0;

    $display("[TB] dbg_lock exclusivity");
    k = cyc;
    for (int j = 0; j < 4; j++) begin
      expectAccess(k + 1 + 4 * j, 1'b0, 8'h33, 8'h00, 1'b1);
      expectAck(1'b1, 8'h77, k + 3 + 4 * j);
    end
    expectAccess(k + 17, 1'b0, 8'h10, 8'h00, 1'b0);
    expectAck(1'b0, 8'hA5, k + 19);
    dbg_lock1 = 1;
    cpu_req1 = 1; cpu_we1 = 0; cpu_addr1 = 8'h10; cpu_wdata1 = 8'h00;
    dbg_req1 = 1; dbg_we1 = 0; dbg_addr1 = 8'h33; dbg_wdata1 = 8'h00;
    cpu_n = 0; dbg_n = 0; cpu_at_unlock = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cpu_ack1) cpu_n++;
      if (dbg_ack1) dbg_n++;
      @(posedge clk);
      #1;
      if (dbg_n == 4 && dbg_req1) begin
        dbg_req1 = 0;
        dbg_lock1 = 0;
        cpu_at_unlock = cpu_n;
      end
      if (cpu_n == 1) begin
        cpu_req1 = 0;
        break;
      end
    end
    checkOutput("lock_cpu_acks", 64'(cpu_at_unlock), 0);
    checkOutput("lock_dbg_acks", 64'(dbg_n), 4);
    cpu_req1 = 0; dbg_req1 = 0; dbg_lock1 = 0;

    $display("[TB] reset during WAIT");
    k = cyc;
    expectAccess(k + 1, 1'b0, 8'h10, 8'h00, 1'b0);
    cpu_req1 = 1; cpu_we1 = 0; cpu_addr1 = 8'h10; cpu_wdata1 = 8'h00;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req1 = 0;
    @(negedge clk);
    checkOutput("wait_busy_before_reset", 64'(busy1), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("after_reset_outputs",
                {busy1, mem_re1, mem_we1, cpu_ack1, dbg_ack1, cpu_rdata1, grant_dbg1}, 0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    applyStimulus('{1'b0, 1'b0, 8'h10, 8'h12, 8'hA5});

    $display("[TB] MEM_LAT=3 read");
    k = cyc;
    re_cyc = -1; ack_cyc = -1; rd = 8'h00;
    cpu_req3 = 1; cpu_we3 = 0; cpu_addr3 = 8'h44; cpu_wdata3 = 8'h00;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (mem_re3) re_cyc = cyc;
      if (cpu_ack3) begin
        ack_cyc = cyc;
        rd = cpu_rdata3;
        break;
      end
    end
    @(posedge clk);
    #1;
    cpu_req3 = 0;
    checkOutput("lat3_re_cycle", 64'(re_cyc - k), 1);
    checkOutput("lat3_ack_cycle", 64'(ack_cyc - k), 5);
    checkOutput("lat3_rdata", 64'(rd), 64'(8'hBB));

    waitDrain(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
